// File: rtl/hash_table.sv
// Shared hash-table constants: data-table address width and the free-address manager state encoding.
package hash_table;

    localparam int unsigned A_WIDTH = 8;
    localparam int unsigned DEPTH   = 1 << A_WIDTH;
    localparam int unsigned CNT_W   = A_WIDTH + 1;

    typedef enum logic {
        EAM_INIT_S,
        EAM_READY_S
    } eam_state_e;

endpackage

// File: rtl/simple_dual_port_ram.sv
// One write port, one registered read port; read data holds when no read is issued.
module simple_dual_port_ram #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/empty_addr_manager.sv
// Free-address ring FIFO for the hash-table data RAM, with a show-ahead output stage.
// Loads every address once after reset so the table starts empty.
module empty_addr_manager
    import hash_table::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    output logic               init_done_o,
    output logic [A_WIDTH-1:0] empty_addr_o,
    output logic               empty_addr_val_o,
    input  logic               empty_addr_rd_ack_i,
    input  logic [A_WIDTH-1:0] add_empty_addr_i,
    input  logic               add_empty_addr_en_i,
    output logic [CNT_W-1:0]   free_cnt_o,
    output logic               err_underflow_o,
    output logic               err_overflow_o
);

    eam_state_e         state_q, state_d;
    logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]   free_cnt_q, free_cnt_d;
    logic               val_q, val_d;
    logic               init_done_q, init_done_d;
    logic               err_uf_q, err_uf_d;
    logic               err_of_q, err_of_d;

    logic               do_pop_c;
    logic               read_en_c;
    logic               push_acc_c;
    logic               ram_we_c;
    logic [A_WIDTH-1:0] ram_waddr_c;
    logic [A_WIDTH-1:0] ram_wdata_c;

    // Next-state, write-mux and pointer/count logic
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        val_d       = val_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = wr_ptr_q;
        ram_wdata_c = add_empty_addr_i;

        do_pop_c   = empty_addr_rd_ack_i & val_q;
        // Registered fifo_cnt gates the read, so a same-cycle push is never read back.
        read_en_c  = (state_q == EAM_READY_S) && (fifo_cnt_q != '0) && (!val_q || do_pop_c);
        push_acc_c = add_empty_addr_en_i && (state_q == EAM_READY_S) &&
                     ((free_cnt_q < CNT_W'(DEPTH)) || do_pop_c);

        case (state_q)
            EAM_INIT_S: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = init_cnt_q;
                ram_wdata_c = init_cnt_q;
                init_cnt_d  = init_cnt_q + A_WIDTH'(1);
                wr_ptr_d    = wr_ptr_q + A_WIDTH'(1);
                fifo_cnt_d  = fifo_cnt_q + CNT_W'(1);
                if (init_cnt_q == A_WIDTH'(DEPTH - 1)) begin
                    state_d = EAM_READY_S;
                end
            end
            default: begin
                if (push_acc_c) begin
                    ram_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
                end
                fifo_cnt_d = fifo_cnt_q + CNT_W'(push_acc_c) - CNT_W'(read_en_c);
                if (read_en_c) begin
                    rd_ptr_d = rd_ptr_q + A_WIDTH'(1);
                    val_d    = 1'b1;
                end else if (do_pop_c) begin
                    val_d = 1'b0;
                end
            end
        endcase

        init_done_d = (state_d == EAM_READY_S);
        free_cnt_d  = fifo_cnt_d + CNT_W'(val_d);
        err_uf_d    = empty_addr_rd_ack_i & ~val_q;
        err_of_d    = add_empty_addr_en_i & ~push_acc_c;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= EAM_INIT_S;
            init_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            free_cnt_q  <= '0;
            val_q       <= 1'b0;
            init_done_q <= 1'b0;
            err_uf_q    <= 1'b0;
            err_of_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            free_cnt_q  <= free_cnt_d;
            val_q       <= val_d;
            init_done_q <= init_done_d;
            err_uf_q    <= err_uf_d;
            err_of_q    <= err_of_d;
        end
    end

    simple_dual_port_ram #(
        .DWIDTH (A_WIDTH),
        .AWIDTH (A_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_c),
        .waddr_i (ram_waddr_c),
        .wdata_i (ram_wdata_c),
        .re_i    (read_en_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (empty_addr_o)
    );

    assign init_done_o      = init_done_q;
    assign empty_addr_val_o = val_q;
    assign free_cnt_o       = free_cnt_q;
    assign err_underflow_o  = err_uf_q;
    assign err_overflow_o   = err_of_q;

endmodule

// File: tb/tb_empty_addr_manager.sv
// Directed bench for empty_addr_manager: init, drain, refill, overflow, push+pop and mid-run reset.
module tb_empty_addr_manager;
    import hash_table::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               init_done;
    logic [A_WIDTH-1:0] empty_addr;
    logic               empty_addr_val;
    logic               rd_ack;
    logic [A_WIDTH-1:0] add_addr;
    logic               add_en;
    logic [CNT_W-1:0]   free_cnt;
    logic               err_uf;
    logic               err_of;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    empty_addr_manager dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .init_done_o         (init_done),
        .empty_addr_o        (empty_addr),
        .empty_addr_val_o    (empty_addr_val),
        .empty_addr_rd_ack_i (rd_ack),
        .add_empty_addr_i    (add_addr),
        .add_empty_addr_en_i (add_en),
        .free_cnt_o          (free_cnt),
        .err_underflow_o     (err_uf),
        .err_overflow_o      (err_of)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release reset and run the full address load; optionally poke push/ack in the first init cycle.
    task automatic do_init(input bit poke);
        int early = 0;
        int n     = 255;
        rst_n = 1'b1;
        if (poke) begin
            rd_ack   = 1'b1;
            add_en   = 1'b1;
            add_addr = 8'h33;
            tick();
            rd_ack = 1'b0;
            add_en = 1'b0;
            check("init_poke_uf", 32'(err_uf), 32'd1);
            check("init_poke_of", 32'(err_of), 32'd1);
            check("init_poke_free", 32'(free_cnt), 32'd1);
            check("init_poke_val", 32'(empty_addr_val), 32'd0);
            if (init_done) early++;
            n = 254;
        end
        for (int i = 0; i < n; i++) begin
            tick();
            if (init_done) early++;
        end
        check("init_early_done", 32'(early), 32'd0);
        tick();
        check("init_done", 32'(init_done), 32'd1);
        check("init_free", 32'(free_cnt), 32'd256);
        check("init_val0", 32'(empty_addr_val), 32'd0);
        tick();
        check("init_first", 32'({empty_addr_val, empty_addr}), 32'h100);
        check("init_free2", 32'(free_cnt), 32'd256);
    endtask

    initial begin
        logic [A_WIDTH-1:0] q[$];
        logic [A_WIDTH-1:0] exp_a;

        rst_n    = 1'b0;
        rd_ack   = 1'b0;
        add_en   = 1'b0;
        add_addr = '0;

        // T1: reset then initial load
        repeat (3) tick();
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_val", 32'(empty_addr_val), 32'd0);
        check("rst_free", 32'(free_cnt), 32'd0);
        check("rst_errs", 32'({err_uf, err_of}), 32'd0);
        do_init(1'b0);

        // T2: drain every address in order
        rd_ack = 1'b1;
        for (int i = 0; i < 256; i++) begin
            check("drain", 32'({empty_addr_val, empty_addr}), 32'h100 | 32'(i));
            tick();
        end
        check("drain_val", 32'(empty_addr_val), 32'd0);
        check("drain_free", 32'(free_cnt), 32'd0);
        check("drain_uf0", 32'(err_uf), 32'd0);
        tick();
        check("uf_pulse", 32'(err_uf), 32'd1);
        check("uf_val", 32'(empty_addr_val), 32'd0);
        check("uf_free", 32'(free_cnt), 32'd0);
        rd_ack = 1'b0;
        tick();
        check("uf_clear", 32'(err_uf), 32'd0);

        // T3: refill from empty
        add_en   = 1'b1;
        add_addr = 8'h2A;
        tick();
        add_en = 1'b0;
        check("refill_val_n1", 32'(empty_addr_val), 32'd0);
        check("refill_free_n1", 32'(free_cnt), 32'd1);
        check("refill_of", 32'(err_of), 32'd0);
        tick();
        check("refill_addr", 32'({empty_addr_val, empty_addr}), 32'h12A);
        check("refill_free", 32'(free_cnt), 32'd1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("refill_pop_val", 32'(empty_addr_val), 32'd0);
        check("refill_pop_free", 32'(free_cnt), 32'd0);

        // T4: overflow when full, accepted with same-cycle pop
        rst_n = 1'b0;
        tick();
        do_init(1'b0);
        add_en   = 1'b1;
        add_addr = 8'h05;
        tick();
        add_en = 1'b0;
        check("of_pulse", 32'(err_of), 32'd1);
        check("of_free", 32'(free_cnt), 32'd256);
        tick();
        check("of_clear", 32'(err_of), 32'd0);
        add_en = 1'b1;
        rd_ack = 1'b1;
        tick();
        add_en = 1'b0;
        check("full_pushpop_of", 32'(err_of), 32'd0);
        check("full_pushpop_free", 32'(free_cnt), 32'd256);
        for (int i = 1; i < 256; i++) begin
            check("full_drain", 32'({empty_addr_val, empty_addr}), 32'h100 | 32'(i));
            tick();
        end
        check("returned_05", 32'({empty_addr_val, empty_addr}), 32'h105);
        check("returned_free", 32'(free_cnt), 32'd1);
        tick();
        rd_ack = 1'b0;
        check("t4_empty_val", 32'(empty_addr_val), 32'd0);
        check("t4_empty_free", 32'(free_cnt), 32'd0);

        // T5: sustained push+pop with 10 held
        add_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            add_addr = 8'h10 + 8'(i);
            q.push_back(add_addr);
            tick();
        end
        add_en = 1'b0;
        repeat (2) tick();
        check("t5_free", 32'(free_cnt), 32'd10);
        rd_ack = 1'b1;
        add_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_a    = q.pop_front();
            add_addr = 8'h80 + 8'(i);
            q.push_back(add_addr);
            check("t5_order", 32'({empty_addr_val, empty_addr}), 32'h100 | 32'(exp_a));
            tick();
            check("t5_free_hold", 32'(free_cnt), 32'd10);
        end
        rd_ack = 1'b0;
        add_en = 1'b0;
        check("t5_of", 32'(err_of), 32'd0);

        // T6: reset mid-operation after 100 pops
        rst_n = 1'b0;
        tick();
        do_init(1'b0);
        rd_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("t6_pop", 32'({empty_addr_val, empty_addr}), 32'h100 | 32'(i));
            tick();
        end
        rd_ack = 1'b0;
        rst_n  = 1'b0;
        tick();
        check("t6_rst_done", 32'(init_done), 32'd0);
        check("t6_rst_val", 32'(empty_addr_val), 32'd0);
        check("t6_rst_free", 32'(free_cnt), 32'd0);
        do_init(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
